ifu_fetch: RTL
==============

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter DATA_LEN, default 32, SHALL set the width of the PC and address datapaths.
REQ-002 Parameter RESET_PC, default 32'h80000000, SHALL be the first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request.
REQ-007 imem_addr  output  DATA_LEN  fetch address, word aligned.
REQ-008 imem_rsp_valid  input  1  fetch data returned.
REQ-009 imem_rdata  input  32  returned instruction word.
REQ-010 inst_valid  output  1  instruction available to decode stage.
REQ-011 inst_ready  input  1  decode stage consumes instruction.
REQ-012 inst  output  32  instruction word.
REQ-013 PC  output  DATA_LEN  address of inst.
REQ-014 PC_S  output  DATA_LEN  PC+4, the sequential successor.
REQ-015 jump_valid  input  1  redirect request from execute/decode.
REQ-016 jump_addr  input  DATA_LEN  redirect target; bits [1:0] ignored, treated as 0.
REQ-017 halt  input  1  level; suppresses new fetch requests (ebreak stop).

Function
REQ-018 The block SHALL hold the register pc and a 3-state FSM: S_REQ, S_WAIT, S_OUT.
REQ-019 imem_addr SHALL equal pc at all times; imem_req_valid = (state==S_REQ) & ~jump_valid & ~halt.
REQ-020 S_REQ: on req handshake (valid&ready) -> S_WAIT; otherwise stay.
REQ-021 S_WAIT: on imem_rsp_valid with drop==0 -> latch imem_rdata into inst, set inst_valid, -> S_OUT; imem_rsp_valid in S_REQ/S_OUT SHALL be ignored.
REQ-022 S_OUT: inst_valid=1; inst, PC, PC_S stable until inst_ready; on inst_ready & ~jump_valid -> pc<=pc+4, inst_valid<=0, -> S_REQ.
REQ-023 Redirect in S_REQ: pc<=jump_addr, stay S_REQ, no request issued that cycle.
REQ-024 Redirect in S_WAIT without rsp: pc<=jump_addr, drop<=1, stay S_WAIT; next rsp discarded, drop<=0, -> S_REQ.
REQ-025 Redirect in S_WAIT coinciding with rsp: rsp discarded, pc<=jump_addr, drop stays 0, -> S_REQ.
REQ-026 Redirect in S_OUT (with or without inst_ready): inst_valid<=0, pc<=jump_addr, -> S_REQ; a coincident inst_ready completes the handshake for the current inst.
REQ-027 PC SHALL equal pc; PC_S = pc+4 modulo 2^DATA_LEN (wrap at all-ones without error).
REQ-028 halt SHALL not cancel an outstanding S_WAIT fetch nor clear a held S_OUT instruction; only S_REQ is blocked.
REQ-029 Minimum latency: request accepted cycle N -> rsp earliest N+1 -> inst_valid high at N+2; sustained throughput at most one instruction per 3 cycles.
REQ-030 At most one request SHALL be outstanding; responses return in order.

Reset
REQ-031 While rst=1 at a clock edge: pc<=RESET_PC, state<=S_REQ, drop<=0, inst_valid<=0, inst<=32'h0.
REQ-032 Reset SHALL take priority over every other event, including mid-S_WAIT and mid-S_OUT; memory is reset by the same rst, so no stale response follows.
REQ-033 First cycle after rst deasserts: imem_req_valid=1, imem_addr=RESET_PC (if halt=0, jump_valid=0).

Verification
REQ-034 Reset release, ready=1, rsp 1 cycle later with 32'h00100093 -> inst_valid at cycle 2, inst=32'h00100093, PC=32'h80000000, PC_S=32'h80000004.
REQ-035 inst_ready held 0 for 5 cycles in S_OUT -> inst/PC unchanged, no new request; ready=1 -> next imem_addr=32'h80000004.
REQ-036 jump_valid in S_WAIT to 32'h80000102, rsp 2 cycles later -> rsp dropped, next imem_addr=32'h80000100, no inst_valid for the dropped word.
REQ-037 jump_valid and imem_rsp_valid same cycle -> no inst_valid, next request at jump target.
REQ-038 pc=32'hFFFFFFFC -> PC_S=32'h00000000; after consume, imem_addr=32'h00000000.
REQ-039 rst asserted in S_OUT -> next cycle inst_valid=0, inst=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Instruction-memory fetch bus: one request channel (valid/ready plus word
// address) and one response channel (valid plus instruction word).
// The fetch unit drives the request side through the master modport; the
// memory drives ready and the response through the slave modport.
interface ifu_fetch_if #(
  parameter int DATA_LEN = 32
);
  logic                req_valid;
  logic                req_ready;
  logic [DATA_LEN-1:0] addr;
  logic                rsp_valid;
  logic [31:0]         rdata;

  modport master (
    output req_valid,
    output addr,
    input  req_ready,
    input  rsp_valid,
    input  rdata
  );

  modport slave (
    input  req_valid,
    input  addr,
    output req_ready,
    output rsp_valid,
    output rdata
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: keeps the fetch PC, issues one memory request at a
// time, holds the returned word for the decode stage and follows redirects.
// A redirect that lands while a request is outstanding marks that response
// for discard so a stale word never reaches decode.
module ifu_fetch #(
  parameter int                  DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  ifu_fetch_if.master         imem,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         inst,
  output logic [DATA_LEN-1:0] PC,
  output logic [DATA_LEN-1:0] PC_S,
  input  logic                jump_valid,
  input  logic [DATA_LEN-1:0] jump_addr,
  input  logic                halt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  localparam logic [DATA_LEN-1:0] ALIGN_MASK = {{(DATA_LEN-2){1'b1}}, 2'b00};
  localparam logic [DATA_LEN-1:0] PC_STEP    = DATA_LEN'(32'd4);

  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] pc_q, pc_d;
  logic                drop_q, drop_d;
  logic                inst_valid_q, inst_valid_d;
  logic [31:0]         inst_q, inst_d;

  logic [DATA_LEN-1:0] jump_tgt_s;
  logic                req_valid_s;

  // Redirect target is forced word aligned; a request is only offered when
  // idle and neither a redirect nor a halt is pending this cycle.
  always_comb begin
    jump_tgt_s  = jump_addr & ALIGN_MASK;
    req_valid_s = (state_q == S_REQ) & ~jump_valid & ~halt;
  end

  // State register; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
    end
  end

  // Next-state logic: request, wait for (or discard) the response, then hold
  // the instruction until decode takes it or a redirect replaces it.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;

    case (state_q)
      S_REQ: begin
        if (jump_valid) begin
          pc_d = jump_tgt_s;
        end else if (req_valid_s && imem.req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end

      S_WAIT: begin
        if (imem.rsp_valid) begin
          if (drop_q) begin
            // Response belongs to a fetch that was redirected away from.
            drop_d  = 1'b0;
            state_d = S_REQ;
            if (jump_valid) begin
              pc_d = jump_tgt_s;
            end else begin
              pc_d = pc_q;
            end
          end else if (jump_valid) begin
            // Redirect in the same cycle as the data: the data is stale.
            pc_d    = jump_tgt_s;
            state_d = S_REQ;
          end else begin
            inst_d       = imem.rdata;
            inst_valid_d = 1'b1;
            state_d      = S_OUT;
          end
        end else if (jump_valid) begin
          // Response still in flight; remember to throw it away.
          pc_d   = jump_tgt_s;
          drop_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_OUT: begin
        if (jump_valid) begin
          inst_valid_d = 1'b0;
          pc_d         = jump_tgt_s;
          state_d      = S_REQ;
        end else if (inst_ready) begin
          inst_valid_d = 1'b0;
          pc_d         = pc_q + PC_STEP;
          state_d      = S_REQ;
        end else begin
          state_d = S_OUT;
        end
      end

      default: begin
        inst_valid_d = 1'b0;
        drop_d       = 1'b0;
        state_d      = S_REQ;
      end
    endcase
  end

  assign imem.req_valid = req_valid_s;
  assign imem.addr      = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign PC             = pc_q;
  assign PC_S           = pc_q + PC_STEP;

endmodule
